// File: rtl/core_pkg.sv
// Shared core definitions: stack-pointer update opcodes and reset value.
package core_pkg;

    localparam logic [2:0] SP_HOLD   = 3'b000;
    localparam logic [2:0] SP_DEC1   = 3'b001;
    localparam logic [2:0] SP_DEC2   = 3'b010;
    localparam logic [2:0] SP_INC1   = 3'b011;
    localparam logic [2:0] SP_INC2   = 3'b100;
    localparam logic [2:0] SP_INC4   = 3'b101;
    localparam logic [2:0] SP_DEC4   = 3'b110;
    localparam logic [2:0] SP_RELOAD = 3'b111;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h000F_FFFF;

endpackage

// File: rtl/stack_pointer.sv
// Downward-growing stack pointer register.
// One update per clock, selected by Control_Mux.
module stack_pointer
    import core_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT)
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [2:0]       Control_Mux,
    output logic [WIDTH-1:0] Output_Signal
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    logic [WIDTH-1:0] sp_q;
    logic [WIDTH-1:0] sp_d;

    // Wrapping is intentional: no flags, no saturation.
    always_comb begin
        sp_d = sp_q;
        case (Control_Mux)
            SP_HOLD:   sp_d = sp_q;
            SP_DEC1:   sp_d = sp_q - ONE;
            SP_DEC2:   sp_d = sp_q - TWO;
            SP_INC1:   sp_d = sp_q + ONE;
            SP_INC2:   sp_d = sp_q + TWO;
            SP_INC4:   sp_d = sp_q + FOUR;
            SP_DEC4:   sp_d = sp_q - FOUR;
            SP_RELOAD: sp_d = SP_INIT;
            default:   sp_d = sp_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            sp_q <= SP_INIT;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign Output_Signal = sp_q;

endmodule

// File: tb/tb_stack_pointer.sv
// Directed vector bench for stack_pointer (default and zero SP_INIT).
module tb_stack_pointer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ctl;
    logic [31:0] sp;
    logic        rst_w;
    logic [2:0]  ctl_w;
    logic [31:0] sp_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_pointer dut (
        .clk           (clk),
        .Rst           (rst),
        .Control_Mux   (ctl),
        .Output_Signal (sp)
    );

    stack_pointer #(.WIDTH(32), .SP_INIT(32'h0)) dut_w (
        .clk           (clk),
        .Rst           (rst_w),
        .Control_Mux   (ctl_w),
        .Output_Signal (sp_w)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  ctl;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] c,
                       input logic [31:0] e, input string n);
        vec_t v;
        v.rst = r;
        v.ctl = c;
        v.exp = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] c,
                        input logic [31:0] e, input string n);
        @(negedge clk);
        rst = r;
        ctl = c;
        @(posedge clk);
        #1;
        check(n, sp, e);
    endtask

    task automatic step_w(input logic r, input logic [2:0] c,
                          input logic [31:0] e, input string n);
        @(negedge clk);
        rst_w = r;
        ctl_w = c;
        @(posedge clk);
        #1;
        check(n, sp_w, e);
    endtask

    initial begin
        rst   = 1'b1;
        ctl   = 3'b000;
        rst_w = 1'b1;
        ctl_w = 3'b000;

        add(1, 3'b000, 32'h000F_FFFF, "reset_hold");
        add(1, 3'b010, 32'h000F_FFFF, "reset_prio");
        add(0, 3'b001, 32'h000F_FFFE, "dec1");
        add(0, 3'b010, 32'h000F_FFFC, "dec2");
        add(0, 3'b011, 32'h000F_FFFD, "inc1");
        add(0, 3'b100, 32'h000F_FFFF, "inc2");
        add(0, 3'b101, 32'h0010_0003, "inc4");
        add(0, 3'b110, 32'h000F_FFFF, "dec4");
        add(0, 3'b111, 32'h000F_FFFF, "reload");
        add(0, 3'b001, 32'h000F_FFFE, "pre_hold_dec1");
        add(0, 3'b010, 32'h000F_FFFC, "pre_hold_dec2");
        for (int i = 0; i < 5; i++)
            add(0, 3'b000, 32'h000F_FFFC, "hold");

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].ctl, vecs[i].exp, vecs[i].name);

        // Reset arriving mid-sequence wins over the pending push.
        step(1, 3'b000, 32'h000F_FFFF, "mid_reset_init");
        step(0, 3'b110, 32'h000F_FFFB, "mid_dec4_a");
        step(0, 3'b110, 32'h000F_FFF7, "mid_dec4_b");
        step(0, 3'b110, 32'h000F_FFF3, "mid_dec4_c");
        step(1, 3'b110, 32'h000F_FFFF, "mid_reset");
        step(0, 3'b001, 32'h000F_FFFE, "post_reset_dec1");

        // RELOAD matches the reset value.
        step(1, 3'b000, 32'h000F_FFFF, "rl_reset");
        step(0, 3'b110, 32'h000F_FFFB, "rl_dec4_a");
        step(0, 3'b110, 32'h000F_FFF7, "rl_dec4_b");
        step(0, 3'b111, 32'h000F_FFFF, "rl_reload");
        step(0, 3'b000, 32'h000F_FFFF, "rl_hold");

        // Modulo wrap with SP_INIT = 0.
        step_w(1, 3'b000, 32'h0000_0000, "wrap_reset");
        step_w(0, 3'b001, 32'hFFFF_FFFF, "wrap_under");
        step_w(0, 3'b011, 32'h0000_0000, "wrap_over");
        step_w(0, 3'b010, 32'hFFFF_FFFE, "wrap_dec2");
        step_w(0, 3'b101, 32'h0000_0002, "wrap_inc4");
        step_w(0, 3'b110, 32'hFFFF_FFFE, "wrap_dec4");
        step_w(0, 3'b100, 32'h0000_0000, "wrap_inc2");
        step_w(0, 3'b111, 32'h0000_0000, "wrap_reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
